seg7_display_scanner: RTL and testbench
=======================================

Name: seg7_display_scanner

Overview:
Downstream consumer of the KGPminiRISC 16-bit `out` bus. It drives a 4-digit, time-multiplexed, common-anode seven-segment display with the hex value of the last processor output. Updates are double-buffered and applied only at frame boundaries, so a digit never mixes old and new values (no tearing). It sits at top level between the processor core and the board pins.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit; legal range >= 2; counter width = $clog2(REFRESH_DIV)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset; synchronous, active-high
data_in  in  16  processor output value
data_valid  in  1  1-cycle strobe; data_in is valid this cycle
blank_lead  in  1  1 = blank leading zero digits
an  out  4  digit enables, active-low; an[0] = least significant nibble
seg  out  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}
dp  out  1  decimal point, active-low; constant 1 (off)
frame_done  out  1  1-cycle pulse on the last cycle of digit 3

Behaviour:
- Reset (rst=1 at a clk edge):
  - div_cnt=0, dig_idx=0, disp_reg=0, pend_reg=0, pending=0.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - At terminal count, dig_idx advances 0->1->2->3->0 (mod 4).
- Frame boundary: terminal count while dig_idx=3.
  - frame_done=1 for that one cycle only.
  - If pending=1: disp_reg<=pend_reg and pending<=0.
- Capture:
  - data_valid=1 sets pend_reg<=data_in and pending<=1.
  - Multiple strobes within one frame: last one wins.
  - disp_reg never changes mid-frame.
- Strobe on a boundary cycle: data_in bypasses pend_reg.
  - disp_reg<=data_in and pending<=0.
  - The value shows in the immediately following frame.
- Output timing: an and seg are registered. They reflect dig_idx and disp_reg with 1-cycle latency.
  - The first lit digit after reset deassert is digit 0, one cycle after the first non-reset edge.
  - Enable pattern per dig_idx: 0->1110, 1->1101, 2->1011, 3->0111.
- Leading-zero blanking (blank_lead=1):
  - Digit k is blanked when every nibble at position k and above is zero, with k>0.
  - A blanked digit outputs an=1111 and seg=1111111 for its whole slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_lead is sampled per slot and takes effect on the next slot.
- Hex decode, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010
  - 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-frame: immediate return to reset state. Any pending value is discarded.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry SEG7_HEX lookup constant (active-low {g..a}).
  - AN_OFF=4'b1111 and SEG_OFF=7'b1111111 constants.
- Sub-module hex_to_seg7: purely combinational nibble->segment decoder using SEG7_HEX. It is reusable by other display blocks.
- Scan counter, buffering and blanking logic stay in seg7_display_scanner.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset: hold rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1, frame_done=0 throughout. After release, frame_done pulses every 16 cycles.
2. Scan order, disp_reg=0: an cycles 1110, 1101, 1011, 0111, each held exactly 4 cycles. seg=1000000 in every slot.
3. Mid-frame update: data_valid with 16'h1234 during digit 1 slot -> digits still show 0 until frame_done. In the next frame, digit0 seg=0011001 (4), digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1).
4. Last wins plus boundary bypass:
   - Strobes 16'h1111 then 16'h2222 in one frame -> only 2222 is ever displayed.
   - Strobe 16'hBEEF on the frame_done cycle -> the following frame shows F, E, E, b on digits 0..3.
5. Blanking, blank_lead=1:
   - data 16'h00A5 -> digit2 and digit3 slots have an=1111; digit0=0010010 (5), digit1=0001000 (A).
   - data 16'h0000 -> only digit0 lit, seg=1000000.
6. Reset mid-frame: strobe 16'hFFFF, then assert rst during digit 2 of the frame before the update lands -> outputs go to the reset values. After release, 0 is displayed and FFFF never appears.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and helpers
package seg7_pkg;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slice.
    localparam logic [15:0][6:0] SEG7_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low segment decoder
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_HEX[i_nibble];

endmodule

// File: rtl/seg7_display_scanner.sv
// rtl/seg7_display_scanner.sv - 4-digit multiplexed hex display with frame-synchronous update
module seg7_display_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        blank_lead,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_dig_idx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pending;
    logic          r_blank;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tc;
    logic          w_boundary;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;
    logic          w_blank;

    assign w_tc       = (r_div_cnt == DIV_MAX);
    assign w_boundary = w_tc && (r_dig_idx == 2'd3);

    always_comb begin
        w_nibble = r_disp[3:0];
        w_blank  = 1'b0;
        case (r_dig_idx)
            2'd0: w_nibble = r_disp[3:0];
            2'd1: begin
                w_nibble = r_disp[7:4];
                w_blank  = r_blank && (r_disp[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble = r_disp[11:8];
                w_blank  = r_blank && (r_disp[15:8] == 8'h00);
            end
            default: begin
                w_nibble = r_disp[15:12];
                w_blank  = r_blank && (r_disp[15:12] == 4'h0);
            end
        endcase
    end

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= 2'd0;
            r_disp    <= 16'h0000;
            r_pend    <= 16'h0000;
            r_pending <= 1'b0;
            r_blank   <= 1'b0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
        end else begin
            r_div_cnt <= w_tc ? '0 : r_div_cnt + CW'(1);
            if (w_tc) begin
                r_dig_idx <= r_dig_idx + 2'd1;
                r_blank   <= blank_lead;
            end
            // A strobe landing on the boundary goes straight to the display buffer.
            if (w_boundary) begin
                if (data_valid) begin
                    r_disp    <= data_in;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_disp    <= r_pend;
                    r_pending <= 1'b0;
                end
            end else if (data_valid) begin
                r_pend    <= data_in;
                r_pending <= 1'b1;
            end
            if (w_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= digit_enable(r_dig_idx);
                r_seg <= w_seg;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_done = w_boundary;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// tb/tb_seg7_display_scanner.sv - self-checking bench for seg7_display_scanner
module tb_seg7_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        blank_lead = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    seg7_display_scanner #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16];

    // Frame-level reference: n counts non-reset edges; a frame spans 16 edges.
    int          n;
    logic [15:0] shown;
    logic [15:0] latest;
    logic        have;
    logic        blank_cur;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_fd;
    int          f_seen;

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        int pos, dig;
        logic [15:0] upper;
        logic        blk;
        rst = r; data_valid = v; data_in = d;
        @(posedge clk);
        if (r) begin
            n = 0; shown = 16'h0; have = 1'b0; blank_cur = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0;
        end else begin
            pos   = n % 16;
            dig   = pos / 4;
            upper = shown >> (4 * dig);
            blk   = blank_cur && (dig > 0) && (upper == 16'h0);
            exp_an  = blk ? 4'hF : ~(4'b0001 << dig);
            exp_seg = blk ? 7'h7F : hex_tab[upper[3:0]];
            if (pos % 4 == 3) blank_cur = blank_lead;
            if (v) begin latest = d; have = 1'b1; end
            if (pos == 15 && have) begin shown = latest; have = 1'b0; end
            n++;
            exp_fd = (n % 16 == 15);
        end
        #1;
        tests++;
        if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || frame_done !== exp_fd) begin
            fails++;
            $display("FAIL model n=%0d: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=1 fd=%b",
                     n, an, seg, dp, frame_done, exp_an, exp_seg, exp_fd);
        end
        if (an != 4'hF && seg == 7'b0001110) f_seen++;
        rst = 1'b0; data_valid = 1'b0;
    endtask

    task automatic run_to_pos(input int t);
        for (int k = 0; k < 20 && (n % 16) != t; k++) step(0, 0, 16'h0);
    endtask

    task automatic wait_fd(input string name);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            step(0, 0, 16'h0);
            got = frame_done;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s: frame_done not seen within 40 cycles, required a pulse", name);
        end
    endtask

    task automatic check_frame(input logic [3:0][3:0] ean, input logic [3:0][6:0] eseg,
                               input string name);
        for (int d = 0; d < 4; d++) begin
            step(0, 0, 16'h0);
            tests++;
            if (an !== ean[d] || seg !== eseg[d]) begin
                fails++;
                $display("FAIL %s digit%0d: an=%b seg=%b, required an=%b seg=%b",
                         name, d, an, seg, ean[d], eseg[d]);
            end
            repeat (3) step(0, 0, 16'h0);
        end
    endtask

    typedef struct {
        logic [15:0]      data;
        logic             blank;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
        string            name;
    } vec_t;

    vec_t vecs [3];

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0] = '{16'h1234, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, "upd_1234"};
        vecs[1] = '{16'h00A5, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b0001000, 7'b0010010}, "blank_00A5"};
        vecs[2] = '{16'h0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, "blank_0000"};
        n = 0; shown = 0; latest = 0; have = 0; blank_cur = 0; f_seen = 0;

        repeat (3) step(1, 0, 16'h0);
        repeat (36) step(0, 0, 16'h0);

        for (int i = 0; i < 3; i++) begin
            blank_lead = vecs[i].blank;
            run_to_pos(5);
            step(0, 1, vecs[i].data);
            wait_fd(vecs[i].name);
            step(0, 0, 16'h0);
            check_frame(vecs[i].an, vecs[i].seg, vecs[i].name);
        end
        blank_lead = 1'b0;

        run_to_pos(5);
        step(0, 1, 16'h1111);
        repeat (3) step(0, 0, 16'h0);
        step(0, 1, 16'h2222);
        wait_fd("last_wins");
        step(0, 0, 16'h0);
        check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {4{7'b0100100}}, "last_wins");

        run_to_pos(15);
        step(0, 1, 16'hBEEF);
        check_frame({4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, "bypass_BEEF");

        run_to_pos(0);
        step(1, 0, 16'h0);
        repeat (3) step(0, 0, 16'h0);
        f_seen = 0;
        run_to_pos(3);
        step(0, 1, 16'hFFFF);
        run_to_pos(9);
        step(1, 0, 16'h0);
        step(1, 0, 16'h0);
        repeat (40) step(0, 0, 16'h0);
        tests++;
        if (f_seen != 0) begin
            fails++;
            $display("FAIL reset_discard: F digit lit %0d times, required 0", f_seen);
        end

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 31) == 0) blank_lead = ~blank_lead;
            step(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
